// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory-access stage with variable-latency data bus
// Optional feature: MEM_MISALIGN_TRAP_EN (misaligned accesses are flagged instead of aligned down)
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_instr,
  input  logic [4:0]  EX_rd,
  input  logic [6:0]  EX_opcode,
  input  logic        EX_regwrite,
  input  logic [31:0] EX_r2,
  input  logic [31:0] EX_alu_result,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic [31:0] MEM_instr,
  output logic [4:0]  MEM_rd,
  output logic [6:0]  MEM_opcode,
  output logic        MEM_regwrite,
  output logic [31:0] MEM_result
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        MEM_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic        is_load, is_store, is_mem, misaligned, issue;
  logic [2:0]  f3;
  logic [1:0]  raw_off, off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign is_load  = (EX_opcode == 7'b0000011);
  assign is_store = (EX_opcode == 7'b0100011);
  assign is_mem   = is_load | is_store;
  assign f3       = EX_instr[14:12];
  assign raw_off  = EX_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_mem && (((f3[1:0] == 2'b01) && raw_off[0]) ||
                                 ((f3[1:0] == 2'b10) && (raw_off != 2'b00)));
  assign off        = raw_off;
`else
  // Without the trap, the offset snaps down to the access size's natural boundary.
  assign misaligned = 1'b0;
  assign off        = (f3[1:0] == 2'b01) ? {raw_off[1], 1'b0} :
                      (f3[1:0] == 2'b10) ? 2'b00 : raw_off;
`endif

  assign issue = is_mem && !misaligned;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = EX_r2;
    case (f3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{EX_r2[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{EX_r2[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_stall = (state == IDLE) ? issue : !dmem_ready;

  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] instr_q, alu_q;
  logic [6:0]  opcode_q;
  logic        regwrite_q, is_load_q;
  logic [31:0] shifted, load_val;

  assign shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = dmem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      MEM_instr    <= 32'd0;
      MEM_rd       <= 5'd0;
      MEM_opcode   <= 7'd0;
      MEM_regwrite <= 1'b0;
      MEM_result   <= 32'd0;
      off_q        <= 2'd0;
      f3_q         <= 3'd0;
      rd_q         <= 5'd0;
      instr_q      <= 32'd0;
      alu_q        <= 32'd0;
      opcode_q     <= 7'd0;
      regwrite_q   <= 1'b0;
      is_load_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      MEM_misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
          MEM_misaligned <= misaligned;
`endif
          if (issue) begin
            off_q        <= off;
            f3_q         <= f3;
            rd_q         <= EX_rd;
            instr_q      <= EX_instr;
            alu_q        <= EX_alu_result;
            opcode_q     <= EX_opcode;
            regwrite_q   <= EX_regwrite;
            is_load_q    <= is_load;
            dmem_req     <= 1'b1;
            dmem_we      <= is_store;
            dmem_addr    <= {EX_alu_result[31:2], 2'b00};
            dmem_be      <= be_c;
            dmem_wdata   <= wdata_c;
            MEM_regwrite <= 1'b0;
            MEM_instr    <= NOP;
            state        <= WAIT;
          end else begin
            MEM_instr    <= EX_instr;
            MEM_rd       <= EX_rd;
            MEM_opcode   <= EX_opcode;
            MEM_regwrite <= EX_regwrite && !misaligned;
            MEM_result   <= EX_alu_result;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            dmem_req     <= 1'b0;
            MEM_instr    <= instr_q;
            MEM_rd       <= rd_q;
            MEM_opcode   <= opcode_q;
            MEM_regwrite <= regwrite_q;
            MEM_result   <= is_load_q ? load_val : alu_q;
            state        <= IDLE;
          end else begin
            MEM_regwrite <= 1'b0;
            MEM_instr    <= NOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RISC-V pipeline. It sits directly downstream of the execute stage and consumes its registered outputs (instruction, rd, opcode, regwrite, r2, ALU result). Loads and stores go out on a variable-latency data-memory request/ready bus. The stage stalls upstream while an access is outstanding and registers the writeback-bound result for the next stage.

## Interface
- No parameters.
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- EX_instr  in  32  instruction from execute; funct3 = EX_instr[14:12]
- EX_rd  in  5  destination register
- EX_opcode  in  7  opcode; 7'b0000011 = load, 7'b0100011 = store
- EX_regwrite  in  1  register write enable
- EX_r2  in  32  store data
- EX_alu_result  in  32  effective address, or result for non-memory ops
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- dmem_ready  in  1  access complete this cycle
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- mem_stall  out  1  combinational; upstream holds EX_* while high
- MEM_instr, MEM_rd, MEM_opcode, MEM_regwrite  out  32/5/7/1  registered pass-through to writeback
- MEM_result  out  32  load data (extended) or EX_alu_result
- MEM_misaligned  out  1  misaligned-access flag (present only when MEM_MISALIGN_TRAP_EN is defined)

## Operation
- FSM states are IDLE and WAIT.
- IDLE, non-memory op:
  - MEM_* <= EX_* and MEM_result <= EX_alu_result.
  - mem_stall=0.
- IDLE, load/store:
  - mem_stall=1.
  - Latch address offset, funct3, rd, instr, opcode, regwrite.
  - Drive dmem_req<=1, dmem_we, dmem_addr, dmem_be, dmem_wdata. State <= WAIT.
  - Issue a bubble to MEM: MEM_regwrite<=0, MEM_instr<=32'h00000013.
- WAIT, dmem_ready=0:
  - mem_stall=1, bubble continues, bus outputs held stable.
- WAIT, dmem_ready=1:
  - mem_stall=0, so upstream advances at this edge.
  - dmem_req<=0.
  - MEM_* <= latched values; MEM_result <= extended load data (stores: EX_alu_result latched, MEM_regwrite as latched).
  - State <= IDLE.
- Byte enables by offset o=addr[1:0]:
  - SB: 4'b0001<<o.
  - SH: 4'b0011<<o.
  - SW: 4'b1111.
- wdata lanes:
  - SB: byte replicated ×4.
  - SH: half replicated ×2.
  - SW: as-is.
- Load extraction:
  - LB/LBU: dmem_rdata[8*o+:8], sign/zero extended.
  - LH/LHU: dmem_rdata[8*o+:16], sign/zero extended.
  - LW: full word.
- dmem_ready outside WAIT is ignored.

## Timing
- Reset (reset=0 at a rising edge):
  - All outputs and internal registers go to 0 (MEM_instr=0).
  - State goes to IDLE and dmem_req drops at that edge, including mid-WAIT. The abandoned access is never written back.
- Non-memory op latency: 1 cycle from EX_* to MEM_*.
- Memory op:
  - dmem_req rises 1 cycle after the op appears on EX_*.
  - MEM_result is valid on the edge after the first cycle with dmem_ready=1.
  - Minimum latency 2 cycles; N wait cycles adds N.
- Back-to-back memory ops: the second op is issued from IDLE the cycle after completion, so dmem_req is low for exactly 1 cycle between them.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned cases are LH/LHU/SH with o odd, and LW/SW with o≠0.
  - No bus request and no stall.
  - MEM_misaligned=1 for one cycle alongside the registered instr, with MEM_regwrite forced to 0.
- MEM_MISALIGN_TRAP_EN not defined:
  - Port absent.
  - Offset is forced to natural alignment: halfword o&2'b10, word 0. The access proceeds normally.

## Test plan
- ADD with EX_alu_result=0x00000042, regwrite=1 -> next cycle MEM_result=0x42, MEM_regwrite=1, mem_stall never high.
- LB addr 0x103, dmem_rdata=0x80FFFFFF, ready 3 cycles after req -> be=4'b1000, dmem_addr=0x100, mem_stall high 4 cycles, MEM_result=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH addr 0x202, EX_r2=0x1234ABCD, ready same cycle -> dmem_we=1, be=4'b1100, wdata=0xABCDABCD, req high exactly 1 cycle.
- LW then SW back-to-back, ready immediate -> two req pulses separated by 1 low cycle; upstream held exactly 1 cycle per op.
- reset=0 during WAIT -> req=0, state IDLE, MEM_regwrite=0 next cycle; a late dmem_ready is ignored.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x301 -> no req, MEM_misaligned=1 for 1 cycle, MEM_regwrite=0. Without the macro -> dmem_addr=0x300, be=4'b1111.
